// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and widths for the 8-requester round-robin mux arbiter.
// Holds the FSM state encoding and a one-hot decode helper.
package mux8_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_TURN
   } arb_state_t;

   function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Rotating-priority encoder: first set request scanning ptr, ptr+1, ... mod 8.
// Purely combinational; o_found is low when no request is set.
module rr_pick_8
   import mux8_arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_found
);

   logic [SEL_W-1:0] w_pos;

   // Scan farthest offset first so the nearest set bit to ptr wins last.
   always_comb begin
      o_idx   = i_ptr;
      o_found = 1'b0;
      w_pos   = i_ptr;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         w_pos = i_ptr + SEL_W'(i);
         if (i_req[w_pos]) begin
            o_idx   = w_pos;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of a shared 8:1 mux: grants one requester, holds while req stays high,
// forces release after MAX_HOLD cycles under contention, with one dead TURN cycle per handover.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             arb_en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             mux_en,
   output logic             busy,
   output logic             preempt
);

   localparam int              CNT_W   = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   arb_state_t       r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] r_sel;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic             r_mux_en;
   logic             r_preempt;

   logic [SEL_W-1:0] w_pick_idx;
   logic             w_pick_found;
   logic             w_can_grant;
   logic             w_owner_req;
   logic             w_contend;
   logic             w_timeout;

   rr_pick_8 u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_idx   (w_pick_idx),
      .o_found (w_pick_found)
   );

   assign w_can_grant = arb_en && w_pick_found;
   assign w_owner_req = req[r_sel];
   assign w_contend   = |(req & ~r_gnt);
   assign w_timeout   = (r_hold_cnt == CNT_MAX) && w_contend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_ptr      <= '0;
         r_sel      <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_mux_en   <= 1'b0;
         r_preempt  <= 1'b0;
      end else begin
         r_preempt <= 1'b0;
         case (r_state)
            ARB_IDLE, ARB_TURN: begin
               if (w_can_grant) begin
                  r_state    <= ARB_GRANT;
                  r_gnt      <= onehot8(w_pick_idx);
                  r_sel      <= w_pick_idx;
                  r_mux_en   <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_state <= ARB_IDLE;
               end
            end
            ARB_GRANT: begin
               if (r_hold_cnt != CNT_MAX)
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               // A release with the owner still requesting can only be a timeout.
               if (!w_owner_req || w_timeout) begin
                  r_state   <= ARB_TURN;
                  r_gnt     <= '0;
                  r_mux_en  <= 1'b0;
                  r_ptr     <= r_sel + SEL_W'(1);
                  r_preempt <= w_owner_req;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   assign gnt     = r_gnt;
   assign sel     = r_sel;
   assign mux_en  = r_mux_en;
   assign busy    = (r_state != ARB_IDLE);
   assign preempt = r_preempt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter (MAX_HOLD=4): vector table, directed corner sequences
// and random traffic compared against an owner/queue-level reference model.
module tb_mux8_rr_arbiter;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       arb_en;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       mux_en;
   logic       busy;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   // Reference model: current owner (-1 = none), cycles owned, dead-cycle flag.
   int m_owner;
   int m_held;
   int m_ptr;
   int m_last;
   bit m_gap;
   bit m_pre;

   typedef struct {
      bit         en;
      logic [7:0] rq;
      logic [7:0] e_gnt;
      logic [2:0] e_sel;
      bit         e_mux;
      bit         e_busy;
      bit         e_pre;
   } vec_t;

   vec_t tbl[29];

   mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .arb_en  (arb_en),
      .req     (req),
      .gnt     (gnt),
      .sel     (sel),
      .mux_en  (mux_en),
      .busy    (busy),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int p);
      for (int i = 0; i < 8; i++)
         if (r[(p + i) % 8]) return (p + i) % 8;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_held = 0; m_ptr = 0; m_last = 0; m_gap = 0; m_pre = 0;
   endtask

   task automatic model_step();
      logic [7:0] others;
      m_pre = 0;
      if (m_owner >= 0) begin
         m_held++;
         others = req & ~(8'(1) << m_owner);
         if (!req[m_owner] || (m_held >= MH && others != 0)) begin
            m_pre   = req[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_gap   = 1;
         end
      end else begin
         m_gap = 0;
         if (arb_en && req != 0) begin
            m_owner = pick(req, m_ptr);
            m_held  = 0;
            m_last  = m_owner;
         end
      end
   endtask

   task automatic model_check();
      chk("m_gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("m_sel", sel, m_last);
      chk("m_mux_en", mux_en, (m_owner >= 0) ? 1 : 0);
      chk("m_busy", busy, (m_owner >= 0 || m_gap) ? 1 : 0);
      chk("m_preempt", preempt, m_pre);
   endtask

   task automatic step(input bit en, input logic [7:0] r);
      arb_en = en;
      req    = r;
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   // Called away from a clock edge: outputs must clear without any edge.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_sel", sel, 0);
      chk("rst_mux_en", mux_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_preempt", preempt, 0);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_grant(input string name, input logic [7:0] r, input logic [7:0] exp);
      logic [7:0] prev;
      int n;
      prev = gnt;
      n = 0;
      do begin
         step(1'b1, r);
         n++;
      end while ((gnt == 8'h00 || gnt == prev) && n < 20);
      chk(name, gnt, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] r;
      tbl[0]  = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 8'h10, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 8'h10, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 8'h21, 8'h20, 3'd5, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 8'h01, 8'h00, 3'd5, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 8'h00, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[21] = '{1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
      tbl[22] = '{1'b1, 8'h0C, 8'h00, 3'd2, 1'b0, 1'b1, 1'b1};
      tbl[23] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[24] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[25] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[26] = '{1'b1, 8'h0C, 8'h08, 3'd3, 1'b1, 1'b1, 1'b0};
      tbl[27] = '{1'b1, 8'h04, 8'h00, 3'd3, 1'b0, 1'b1, 1'b0};
      tbl[28] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};

      rst    = 1'b1;
      arb_en = 1'b0;
      req    = 8'h00;
      #3;
      do_reset();

      for (int i = 0; i < 29; i++) begin
         step(tbl[i].en, tbl[i].rq);
         chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].e_gnt);
         chk($sformatf("vec%0d_sel", i), sel, tbl[i].e_sel);
         chk($sformatf("vec%0d_mux_en", i), mux_en, tbl[i].e_mux);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("vec%0d_preempt", i), preempt, tbl[i].e_pre);
      end

      // Mid-grant asynchronous reset (owner 2 still holds the mux here).
      do_reset();

      // Full contention: 0..7,0 each for MH cycles, preempt on every handover.
      for (int g = 0; g < 9; g++) begin
         for (int c = 0; c < MH; c++) begin
            step(1'b1, 8'hFF);
            chk("ff_gnt", gnt, 1 << (g % 8));
         end
         step(1'b1, 8'hFF);
         chk("ff_turn_gnt", gnt, 0);
         chk("ff_preempt", preempt, 1);
      end

      do_reset();
      step(1'b1, 8'h04);
      chk("rot_first", gnt, 8'h04);
      step(1'b1, 8'h83);
      chk("rot_release", gnt, 8'h00);
      next_grant("rot_g7", 8'h87, 8'h80);
      next_grant("rot_g0", 8'h87, 8'h01);
      next_grant("rot_g1", 8'h87, 8'h02);

      do_reset();
      for (int c = 0; c < 100; c++) begin
         step(1'b1, 8'h20);
         chk("solo_gnt", gnt, 8'h20);
         chk("solo_preempt", preempt, 0);
      end

      do_reset();
      r = 8'h00;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         if ($urandom_range(0, 150) == 0) begin
            #2;
            do_reset();
         end
         step($urandom_range(0, 7) != 0, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
